// File: rtl/red_pitaya_pkg.sv
// Shared constants and types for the slow-DAC PWM update scheduler.
package red_pitaya_pkg;

    localparam int unsigned PWM_FULL_DEF = 156;
    localparam int unsigned PWM_DW       = 24;
    localparam int unsigned PWM_INT_W    = 8;
    localparam int unsigned PWM_DITH_W   = PWM_DW - PWM_INT_W;
    localparam int unsigned PWM_CH_N     = 4;
    localparam int unsigned N_REQ        = 2;
    localparam int unsigned CNT_W        = 16;

    typedef enum logic [1:0] {
        CH_A = 2'd0,
        CH_B = 2'd1,
        CH_C = 2'd2,
        CH_D = 2'd3
    } pwm_chan_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } sched_state_e;

endpackage

// File: rtl/red_pitaya_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered preference pointer.
module red_pitaya_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic       gnt_vld_c,
    output logic       gnt_idx_c
);

    logic rr_q;
    logic rr_d;

    // Pick the preferred requester on contention, otherwise the only one asking.
    always_comb begin
        gnt_vld_c = |req_i;
        gnt_idx_c = 1'b0;
        rr_d      = rr_q;
        if (req_i == 2'b11) begin
            gnt_idx_c = rr_q;
        end else begin
            gnt_idx_c = req_i[1];
        end
        if (en_i && gnt_vld_c) begin
            rr_d = ~gnt_idx_c;
        end
    end

    // Preference pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/red_pitaya_pwm_sched.sv
// Slow-DAC update scheduler: arbitrated writes into per-channel shadows,
// committed to the PWM generator only on its sync pulse.
module red_pitaya_pwm_sched
    import red_pitaya_pkg::*;
#(
    parameter int unsigned PWM_FULL = PWM_FULL_DEF,
    parameter int unsigned DW       = PWM_DW
) (
    input  logic             dac_2clk_i,
    input  logic             dac_rst_i,
    input  logic             pwm_sync_i,
    input  logic [1:0]       req_i,
    input  logic [1:0]       chan0_i,
    input  logic [1:0]       chan1_i,
    input  logic [DW-1:0]    dat0_i,
    input  logic [DW-1:0]    dat1_i,
    output logic [1:0]       ack_o,
    output logic [DW-1:0]    dac_pwm_a_o,
    output logic [DW-1:0]    dac_pwm_b_o,
    output logic [DW-1:0]    dac_pwm_c_o,
    output logic [DW-1:0]    dac_pwm_d_o,
    output logic [3:0]       pend_o,
    output logic [3:0]       ovr_o,
    input  logic             ovr_clr_i,
    output logic [CNT_W-1:0] commit_cnt_o
);

    localparam int unsigned DITH_W = DW - PWM_INT_W;
    localparam logic [PWM_INT_W-1:0] FULL_INT = PWM_INT_W'(PWM_FULL);

    sched_state_e        state_q, state_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [DW-1:0]       shadow_q [PWM_CH_N];
    logic [DW-1:0]       shadow_d [PWM_CH_N];
    logic [DW-1:0]       out_q    [PWM_CH_N];
    logic [DW-1:0]       out_d    [PWM_CH_N];
    logic [PWM_CH_N-1:0] pend_q, pend_d;
    logic [PWM_CH_N-1:0] ovr_q, ovr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                arb_en_c;
    logic                gnt_vld_c;
    logic                gnt_idx_c;
    logic                wr_en_c;
    pwm_chan_e           wr_ch_c;
    logic [DW-1:0]       wr_dat_c;
    logic [DW-1:0]       wr_val_c;
    logic [PWM_CH_N-1:0] wr_mask_c;
    logic [PWM_CH_N-1:0] commit_mask_c;
    logic [PWM_CH_N-1:0] ovr_set_c;

    assign arb_en_c = (state_q == ST_IDLE);

    red_pitaya_rr_arb2 u_arb (
        .clk       (dac_2clk_i),
        .rst       (dac_rst_i),
        .en_i      (arb_en_c),
        .req_i     (req_i),
        .gnt_vld_c (gnt_vld_c),
        .gnt_idx_c (gnt_idx_c)
    );

    // Select the granted requester's channel/value and clamp to full scale.
    always_comb begin
        wr_ch_c  = pwm_chan_e'(gnt_idx_c ? chan1_i : chan0_i);
        wr_dat_c = gnt_idx_c ? dat1_i : dat0_i;
        wr_val_c = wr_dat_c;
        if (wr_dat_c[DW-1 -: PWM_INT_W] >= FULL_INT) begin
            wr_val_c = {FULL_INT, DITH_W'(0)};
        end
    end

    // Handshake FSM: grant in IDLE, hold off new grants during the ack cycle.
    always_comb begin
        state_d = state_q;
        ack_d   = '0;
        wr_en_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld_c) begin
                    wr_en_c            = 1'b1;
                    ack_d[gnt_idx_c]   = 1'b1;
                    state_d            = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadow write, sync commit (old shadow wins on collision) and status.
    always_comb begin
        wr_mask_c     = wr_en_c ? (PWM_CH_N'(1) << wr_ch_c) : '0;
        commit_mask_c = pwm_sync_i ? pend_q : '0;
        ovr_set_c     = wr_mask_c & pend_q & ~commit_mask_c;
        pend_d        = (pend_q & ~commit_mask_c) | wr_mask_c;
        ovr_d         = (ovr_clr_i ? '0 : ovr_q) | ovr_set_c;
        cnt_d         = cnt_q + CNT_W'(|commit_mask_c);
        for (int i = 0; i < PWM_CH_N; i++) begin
            shadow_d[i] = wr_mask_c[i]     ? wr_val_c    : shadow_q[i];
            out_d[i]    = commit_mask_c[i] ? shadow_q[i] : out_q[i];
        end
    end

    // All state and output registers.
    always_ff @(posedge dac_2clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            state_q <= ST_IDLE;
            ack_q   <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < PWM_CH_N; i++) begin
                shadow_q[i] <= '0;
                out_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < PWM_CH_N; i++) begin
                shadow_q[i] <= shadow_d[i];
                out_q[i]    <= out_d[i];
            end
        end
    end

    assign ack_o        = ack_q;
    assign pend_o       = pend_q;
    assign ovr_o        = ovr_q;
    assign commit_cnt_o = cnt_q;
    assign dac_pwm_a_o  = out_q[CH_A];
    assign dac_pwm_b_o  = out_q[CH_B];
    assign dac_pwm_c_o  = out_q[CH_C];
    assign dac_pwm_d_o  = out_q[CH_D];

endmodule
